// File: rtl/hada_pkg.sv
// Shared hada types and helpers for the narrow/wide lane utilities.
package hada;

  typedef logic [63:0] ulongint;

  function automatic int lanesOf(int ew);
    return 64 / ew;
  endfunction

endpackage

// File: rtl/hada_widen_pack_lane_insert.sv
// Combinational lane insert: writes in_data into lane idx of acc, keeps lower lanes, zeroes lanes above idx.
module hada_lane_insert
  import hada::*;
#(
  parameter  int EW    = 8,
  localparam int LANES = lanesOf(EW),
  localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  ulongint         acc,
  input  logic [IW-1:0]   idx,
  input  logic [EW-1:0]   in_data,
  output ulongint         word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (IW'(i) < idx) begin
        word[i*EW +: EW] = acc[i*EW +: EW];
      end else if (IW'(i) == idx) begin
        word[i*EW +: EW] = in_data;
      end
    end
  end

endmodule

// File: rtl/hada_widen_pack.sv
// Stream upsizer: packs EW-bit elements into 64-bit words, lane 0 in the LSBs; in_last closes a word early.
// Optional per-word valid-lane count on out_cnt when HADA_WIDEN_PACK_CNT_EN is defined.
module hada_widen_pack
  import hada::*;
#(
  parameter  int EW    = 8,
  localparam int LANES = lanesOf(EW),
  localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int CW    = $clog2(LANES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output ulongint       out_data,
  output logic          out_last
`ifdef HADA_WIDEN_PACK_CNT_EN
  ,
  output logic [CW-1:0] out_cnt
`endif
);

  if (!(EW == 8 || EW == 16 || EW == 32 || EW == 64)) begin : g_bad_ew
    $error("hada_widen_pack: EW must be 8, 16, 32 or 64");
  end

  ulongint       acc_q, acc_d;
  ulongint       out_data_q, out_data_d;
  ulongint       ins_word;
  logic [IW-1:0] idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          out_free, accept, complete;

  hada_lane_insert #(.EW(EW)) u_insert (
    .acc    (acc_q),
    .idx    (idx_q),
    .in_data(in_data),
    .word   (ins_word)
  );

  always_comb begin
    out_free    = !out_valid_q || out_ready;
    accept      = in_valid && out_free;
    complete    = (idx_q == IW'(LANES - 1)) || in_last;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (complete) begin
        // A completing accept overrides the drain above, so words stream back-to-back.
        out_data_d  = ins_word;
        out_last_d  = in_last;
        out_valid_d = 1'b1;
        acc_d       = '0;
        idx_d       = '0;
      end else begin
        for (int i = 0; i < LANES; i++) begin
          if (IW'(i) == idx_q) begin
            acc_d[i*EW +: EW] = in_data;
          end
        end
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef HADA_WIDEN_PACK_CNT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && complete) begin
      cnt_d = CW'(idx_q) + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`endif

  assign in_ready  = out_free;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
